// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer for the RV32I core.
// Fetches over a req/ack port, holds the word for decode, and advances on pc_load.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_alu_sel,
    input  logic [31:0] alu_out,
    input  logic        pc_load,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] insn,
    output logic        insn_valid,
    output logic        misalign_err,
    output logic        fetch_err
);

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_VALID = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_r, pc_nxt;
    logic [31:0] insn_r, insn_nxt;
    logic [31:0] target;
    logic [7:0]  tmo_cnt, tmo_nxt;
    logic        mis_r, mis_nxt;
    logic        ferr_r, ferr_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_FETCH;
            pc_r    <= RESET_PC;
            insn_r  <= NOP;
            tmo_cnt <= 8'd0;
            mis_r   <= 1'b0;
            ferr_r  <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc_r    <= pc_nxt;
            insn_r  <= insn_nxt;
            tmo_cnt <= tmo_nxt;
            mis_r   <= mis_nxt;
            ferr_r  <= ferr_nxt;
        end
    end

    assign pc_plus4 = pc_r + 32'd4;
    assign target   = pc_alu_sel ? alu_out : pc_plus4;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_r;
        insn_nxt  = insn_r;
        tmo_nxt   = tmo_cnt;
        mis_nxt   = mis_r;
        ferr_nxt  = ferr_r;
        case (state)
            S_FETCH: begin
                if (imem_ack) begin
                    insn_nxt  = imem_rdata;
                    tmo_nxt   = 8'd0;
                    state_nxt = S_VALID;
                end else begin
                    tmo_nxt = tmo_cnt + 8'd1;
                    // this cycle is the TIMEOUT_CYCLES-th one without an ack
                    if (tmo_cnt == TMO_LAST) begin
                        ferr_nxt  = 1'b1;
                        state_nxt = S_HALT;
                    end
                end
            end
            S_VALID: begin
                if (pc_load) begin
                    if (target[1:0] == 2'b00) begin
                        pc_nxt    = target;
                        state_nxt = S_FETCH;
                    end else begin
                        mis_nxt   = 1'b1;
                        state_nxt = S_HALT;
                    end
                end
            end
            default: ;
        endcase
    end

    // state already reads FETCH while reset is held, so gate the request off
    assign imem_req     = (state == S_FETCH) && !reset;
    assign imem_addr    = pc_r;
    assign pc           = pc_r;
    assign insn         = insn_r;
    assign insn_valid   = (state == S_VALID);
    assign misalign_err = mis_r;
    assign fetch_err    = ferr_r;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized bench for pc_fetch_unit against a cycle-level behavioural model.
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          TMO    = 12;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pc_alu_sel = 1'b0;
    logic [31:0] alu_out = '0;
    logic        pc_load = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req;
    logic [31:0] imem_addr, pc, pc_plus4, insn;
    logic        insn_valid, misalign_err, fetch_err;

    pc_fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .pc_alu_sel(pc_alu_sel), .alu_out(alu_out),
        .pc_load(pc_load), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .imem_req(imem_req), .imem_addr(imem_addr), .pc(pc), .pc_plus4(pc_plus4),
        .insn(insn), .insn_valid(insn_valid), .misalign_err(misalign_err),
        .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [31:0] m_pc, m_insn;
    bit          m_valid, m_fetching, m_halt, m_mis, m_ferr;
    int          m_wait;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = RST_PC; m_insn = 32'h0000_0013; m_valid = 0; m_fetching = 1;
        m_halt = 0; m_mis = 0; m_ferr = 0; m_wait = 0;
    endtask

    task automatic model_step(input bit ack, input logic [31:0] rdata, input bit load,
                              input bit sel, input logic [31:0] alu);
        logic [31:0] nxt;
        if (m_halt) return;
        if (m_fetching) begin
            if (ack) begin
                m_insn = rdata; m_valid = 1; m_fetching = 0; m_wait = 0;
            end else begin
                m_wait++;
                if (m_wait >= TMO) begin m_ferr = 1; m_halt = 1; end
            end
        end else if (load) begin
            nxt = sel ? alu : m_pc + 32'd4;
            m_valid = 0;
            if (nxt % 4 == 0) begin m_pc = nxt; m_fetching = 1; end
            else begin m_mis = 1; m_halt = 1; end
        end
    endtask

    task automatic check_all();
        chk("pc", pc, m_pc);
        chk("imem_addr", imem_addr, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("insn", insn, m_insn);
        chk("insn_valid", {31'd0, insn_valid}, {31'd0, m_valid});
        chk("imem_req", {31'd0, imem_req}, {31'd0, m_fetching && !m_halt});
        chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
        chk("fetch_err", {31'd0, fetch_err}, {31'd0, m_ferr});
    endtask

    // drive one cycle of inputs at the negedge, let the posedge act, check at the next negedge
    task automatic cyc(input bit ack, input logic [31:0] rdata, input bit load,
                       input bit sel, input logic [31:0] alu);
        imem_ack = ack; imem_rdata = rdata; pc_load = load; pc_alu_sel = sel; alu_out = alu;
        model_step(ack, rdata, load, sel, alu);
        @(negedge clk);
        check_all();
    endtask

    // async reset asserted mid-cycle, held across one posedge
    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_pc", pc, RST_PC);
        chk("rst_insn", insn, 32'h0000_0013);
        chk("rst_flags", {28'd0, imem_req, insn_valid, misalign_err, fetch_err}, 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_all();
    endtask

    // from VALID, jump to addr and complete its fetch
    task automatic goto_pc(input logic [31:0] addr);
        cyc(0, 0, 1, 1, addr);
        cyc(1, $urandom, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();
        chk("req_after_reset", {31'd0, imem_req}, 32'd1);

        // zero-wait fetch
        cyc(1, 32'h00520463, 0, 0, 0);
        chk("t1_insn", insn, 32'h00520463);
        chk("t1_valid", {31'd0, insn_valid}, 32'd1);
        chk("t1_pc", pc, 32'h0);

        // sequential advance
        goto_pc(32'h100);
        cyc(0, 0, 1, 0, 32'h0);
        chk("t2_pc", pc, 32'h104);
        chk("t2_req", {31'd0, imem_req}, 32'd1);
        chk("t2_valid", {31'd0, insn_valid}, 32'd0);

        // taken branch
        cyc(1, $urandom, 0, 0, 0);
        goto_pc(32'h100);
        cyc(0, 0, 1, 1, 32'h108);
        chk("t3_pc", pc, 32'h108);
        chk("t3_addr", imem_addr, 32'h108);

        // misaligned target halts; later activity ignored
        cyc(1, $urandom, 0, 0, 0);
        goto_pc(32'h100);
        cyc(0, 0, 1, 1, 32'h10A);
        chk("t4_mis", {31'd0, misalign_err}, 32'd1);
        chk("t4_pc", pc, 32'h100);
        for (int i = 0; i < 4; i++) cyc(1, $urandom, 1, 0, 32'h200);
        chk("t4_frozen_pc", pc, 32'h100);
        chk("t4_frozen_req", {31'd0, imem_req | insn_valid}, 32'd0);

        // fetch timeout boundary
        @(negedge clk);
        do_reset();
        for (int i = 0; i < TMO - 1; i++) cyc(0, 0, 0, 0, 0);
        chk("t5_no_err_yet", {31'd0, fetch_err}, 32'd0);
        cyc(0, 0, 0, 0, 0);
        chk("t5_ferr", {31'd0, fetch_err}, 32'd1);
        chk("t5_req", {31'd0, imem_req}, 32'd0);
        do_reset();
        chk("t5_clear", {30'd0, misalign_err, fetch_err}, 32'd0);

        // PC+4 wrap, and pc_load ignored during FETCH
        cyc(1, $urandom, 0, 0, 0);
        goto_pc(32'hFFFF_FFFC);
        cyc(0, 0, 1, 0, 32'h0);
        chk("t6_wrap", pc, 32'h0);
        chk("t6_noerr", {31'd0, misalign_err}, 32'd0);
        cyc(0, 0, 1, 1, 32'h200);
        chk("t6_fetch_load", pc, 32'h0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ((m_halt && $urandom_range(0, 5) == 0) || $urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                logic [31:0] a;
                a = $urandom;
                if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
                cyc($urandom_range(0, 9) < 4, $urandom, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 1) == 1, a);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
